div: RTL
========

# div

Multi-cycle 32-bit integer divider for the execute stage of the five-stage pipeline. The execute stage decodes DIV/DIVU from the operation delivered by the decode-to-execute register, raises `start_i`, and holds the pipeline stall request until `ready_o`. The divider then returns a 64-bit result, `{remainder, quotient}`, which the execute stage writes to HI/LO. The division is radix-2 restoring trial subtraction, one quotient bit per clock, with a flush-driven cancel input.

## Interface
Parameters: none (widths fixed by the codebase's `RegBus` and `DoubleRegBus` defines).
- `clk`  in  1  pipeline clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; `rst == 0` forces reset immediately, independent of `clk`.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  32  dividend.
- `opdata2_i`  in  32  divisor.
- `start_i`  in  1  request; held high by the execute stage until it has consumed `ready_o`.
- `annul_i`  in  1  cancel (pipeline flush); overrides `start_i`.
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`; valid only while `ready_o` = 1, otherwise 0.
- `ready_o`  out  1  result valid.

## Operation
- Internal state:
  - 2-bit FSM with states DivFree, DivByZero, DivOn and DivEnd.
  - 6-bit counter `cnt`.
  - 65-bit working register `dividend`.
  - 32-bit latched `divisor`.
- Reset: go to DivFree; `cnt` = 0; `dividend` = 0; `result_o` = 0; `ready_o` = 0.
- DivFree:
  - If `start_i` = 1 and `annul_i` = 0 and `opdata2_i` = 0, go to DivByZero.
  - If `start_i` = 1 and `annul_i` = 0 and `opdata2_i` ≠ 0, go to DivOn. On this transition:
    - `cnt` = 0.
    - Each operand is replaced by its two's-complement absolute value when `signed_div_i` = 1 and its bit 31 is 1.
    - `dividend` = `{32'b0, |A|, 1'b0}`; `divisor` = `|B|`.
    - The operands and the signed flag are sampled here only. Later input changes are ignored.
  - Otherwise stay in DivFree.
- DivByZero: unconditionally go to DivEnd, with `dividend` = 0 so the result is 0.
- DivOn:
  - If `annul_i` = 1, go to DivFree; `cnt` = 0; outputs stay 0.
  - Else if `cnt` ≠ 32, perform one iteration:
    - `diff = {1'b0, dividend[63:32]} - {1'b0, divisor}`.
    - If `diff[32]` = 1: `dividend` = `{dividend[63:0], 1'b0}`.
    - Else: `dividend` = `{diff[31:0], dividend[31:0], 1'b1}`.
    - `cnt` = `cnt` + 1.
  - Else (`cnt` = 32), finish and go to DivEnd:
    - Quotient = `dividend[31:0]`, negated when signed and the operand signs differ.
    - Remainder = `dividend[64:33]`, negated when signed and the dividend is negative.
    - Drive `result_o` = `{rem, quo}` and `ready_o` = 1.
- DivEnd:
  - Hold `result_o` and `ready_o`.
  - When `start_i` = 0, go to DivFree and clear `result_o` and `ready_o`.
- Arithmetic: all operations are 32-bit modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no trap. Remainder sign follows the dividend (MIPS semantics).

## Timing
- Call the edge that samples an accepted `start_i` E0.
- Nonzero divisor:
  - Iterations occur at E1 through E32.
  - Finish occurs at E33, so `ready_o` goes high after E33 (33-cycle latency).
- Zero divisor: `ready_o` goes high after E1, with `result_o` = 0.
- `ready_o` and `result_o` stay stable while `start_i` stays high. They drop one edge after `start_i` falls.
- A new start is accepted only from DivFree, so there is one idle cycle minimum between operations.
- Annul:
  - Annul in DivOn takes effect at the next edge.
  - Annul in DivByZero is ignored; DivEnd follows.
  - Annul in DivEnd is ignored. Release happens via `start_i` only.
- `rst` low at any time, including mid-division, clears all outputs asynchronously, within the same cycle. The first edge after `rst` returns high may accept a start.

## Test plan
- DIVU 100 / 7, `start_i` held high → `ready_o` rises exactly 33 cycles after acceptance; `result_o` = 0x00000002_0000000E; both clear one cycle after `start_i` drops.
- DIV -7 / 2 (0xFFFFFFF9, 0x00000002) → `result_o` = 0xFFFFFFFF_FFFFFFFD. DIV 7 / -2 → 0x00000001_FFFFFFFD.
- Divide by zero (DIV 5 / 0) → `ready_o` after 2 edges; `result_o` = 0.
- Boundary cases:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
  - DIVU 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
  - DIVU 3 / 0xFFFFFFFF → 0x00000003_00000000.
- Assert `annul_i` at iteration 10 → FSM returns to DivFree and `ready_o` never rises. A following DIVU 9 / 3 then completes with 0x00000000_00000003.
- Pull `rst` low mid-edge at iteration 20 → `ready_o` = 0 and `result_o` = 0 before the next rising edge. After release, a fresh DIVU 50 / 5 yields 0x00000000_0000000A in 33 cycles.

Source files
------------

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_if
//  Description : Request/response bundle between the execute stage and the
//                multi-cycle divider.
//                  signed_div_i  1 = DIV (two's complement), 0 = DIVU
//                  opdata1_i     dividend
//                  opdata2_i     divisor
//                  start_i       request, held until ready_o is consumed
//                  annul_i       pipeline-flush cancel, overrides start_i
//                  result_o      {remainder, quotient}, 0 unless ready_o
//                  ready_o       result valid
//  Revision    : 1.0  initial release
// ============================================================================
interface div_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   // Execute stage side: issues requests, consumes results.
   modport master (
      output signed_div_i,
      output opdata1_i,
      output opdata2_i,
      output start_i,
      output annul_i,
      input  result_o,
      input  ready_o
   );

   // Divider side.
   modport slave (
      input  signed_div_i,
      input  opdata1_i,
      input  opdata2_i,
      input  start_i,
      input  annul_i,
      output result_o,
      output ready_o
   );
endinterface
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module      : div
//  Description : 32-bit radix-2 restoring divider, one quotient bit per clock.
//                Handles DIV (signed, MIPS remainder-follows-dividend) and
//                DIVU. Result is {remainder, quotient} held until start_i
//                drops. Divide-by-zero yields a zero result after one cycle.
//  Ports       : clk   pipeline clock, rising edge
//                rst   asynchronous active-low reset
//                bus   div_if.slave (operands, start/annul, result/ready)
//  Revision    : 1.0  initial release
// ============================================================================
module div (
   input  logic  clk,
   input  logic  rst,
   div_if.slave  bus
);

   typedef enum logic [1:0] {
      DIV_FREE    = 2'd0,
      DIV_BY_ZERO = 2'd1,
      DIV_ON      = 2'd2,
      DIV_END     = 2'd3
   } state_t;

   localparam logic [5:0] ITERATIONS = 6'd32;

   state_t      state_q,    state_d;
   logic [5:0]  cnt_q,      cnt_d;
   // Bits [64:33] hold the partial remainder, [31:0] collect quotient bits;
   // the extra low bit lets the shift-in of each quotient bit line up.
   logic [64:0] dividend_q, dividend_d;
   logic [31:0] divisor_q,  divisor_d;
   // Sign corrections decided from the operands sampled at acceptance.
   logic        neg_quo_q,  neg_quo_d;
   logic        neg_rem_q,  neg_rem_d;
   logic [63:0] result_q,   result_d;
   logic        ready_q,    ready_d;

   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] diff;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // Magnitudes of the incoming operands (only consumed on acceptance).
   always_comb begin
      abs_a = bus.opdata1_i;
      abs_b = bus.opdata2_i;
      if (bus.signed_div_i && bus.opdata1_i[31]) begin
         abs_a = ~bus.opdata1_i + 32'd1;
      end
      if (bus.signed_div_i && bus.opdata2_i[31]) begin
         abs_b = ~bus.opdata2_i + 32'd1;
      end
   end

   // Trial subtraction; diff[32] set means the divisor did not fit.
   assign diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};

   // Final sign fix-up of the unsigned quotient and remainder.
   always_comb begin
      quo_fix = dividend_q[31:0];
      rem_fix = dividend_q[64:33];
      if (neg_quo_q) begin
         quo_fix = ~dividend_q[31:0] + 32'd1;
      end
      if (neg_rem_q) begin
         rem_fix = ~dividend_q[64:33] + 32'd1;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;
      ready_d    = ready_q;

      case (state_q)
         DIV_FREE: begin
            if (bus.start_i && !bus.annul_i) begin
               if (bus.opdata2_i == 32'd0) begin
                  state_d    = DIV_BY_ZERO;
                  dividend_d = '0;
               end else begin
                  state_d    = DIV_ON;
                  cnt_d      = 6'd0;
                  dividend_d = {32'd0, abs_a, 1'b0};
                  divisor_d  = abs_b;
                  neg_quo_d  = bus.signed_div_i &
                               (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                  neg_rem_d  = bus.signed_div_i & bus.opdata1_i[31];
               end
            end
         end

         // Flush is deliberately ignored here: the zero result is always
         // delivered and released through start_i.
         DIV_BY_ZERO: begin
            state_d    = DIV_END;
            dividend_d = '0;
            result_d   = '0;
            ready_d    = 1'b1;
         end

         DIV_ON: begin
            if (bus.annul_i) begin
               state_d  = DIV_FREE;
               cnt_d    = 6'd0;
               result_d = '0;
               ready_d  = 1'b0;
            end else if (cnt_q != ITERATIONS) begin
               if (diff[32]) begin
                  dividend_d = {dividend_q[63:0], 1'b0};
               end else begin
                  dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
               end
               cnt_d = cnt_q + 6'd1;
            end else begin
               state_d  = DIV_END;
               cnt_d    = 6'd0;
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
            end
         end

         DIV_END: begin
            if (!bus.start_i) begin
               state_d  = DIV_FREE;
               result_d = '0;
               ready_d  = 1'b0;
            end
         end

         default: begin
            state_d  = DIV_FREE;
            result_d = '0;
            ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= DIV_FREE;
         cnt_q      <= 6'd0;
         dividend_q <= '0;
         divisor_q  <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= '0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.result_o = result_q;
   assign bus.ready_o  = ready_q;

endmodule
`default_nettype wire
